// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word and buffers the
// results in a small FIFO. Define INSTR_ENCODER_RANGE_CHECK_EN to reject immediates that do not fit.
module instr_encoder #(
    parameter int FIFO_DEPTH = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [6:0]           i_opcode,
    input  logic [4:0]           i_rd,
    input  logic [4:0]           i_rs1,
    input  logic [4:0]           i_rs2,
    input  logic [2:0]           i_funct3,
    input  logic [6:0]           i_funct7,
    input  logic [11:0]          i_csr,
    input  logic [31:0]          i_imm,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [31:0]          o_instr,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [31:0] NOP      = 32'h00000013;

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } entry_t;

    entry_t              r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_count;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic [31:0] w_enc;
    logic        w_illegal;
    logic        w_range_bad;
    logic        w_bad;
    logic        w_is_shift;
    logic        w_push;
    logic        w_pop;
    entry_t      w_entry;

    assign w_is_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);

    always_comb begin
        w_enc     = NOP;
        w_illegal = 1'b0;
        case (i_opcode)
            OP_LUI, OP_AUIPC: w_enc = {i_imm[31:12], i_rd, i_opcode};
            OP_JAL:    w_enc = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
            OP_BRANCH: w_enc = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                                i_imm[4:1], i_imm[11], i_opcode};
            OP_STORE:  w_enc = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            OP_LOAD, OP_JALR: w_enc = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            OP_IMM: begin
                if (w_is_shift) w_enc = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
                else            w_enc = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            end
            OP_REG:    w_enc = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            OP_SYSTEM: w_enc = {i_csr, i_imm[4:0], i_funct3, i_rd, i_opcode};
            default:   w_illegal = 1'b1;
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    // True when i_imm[31:lsb] is all zeros or all ones, i.e. the value sign-extends from bit lsb.
    function automatic logic f_sext_ok(input logic [31:0] v, input int lsb);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << lsb;
        return ((v & m) == m) || ((v & m) == 32'h0);
    endfunction

    always_comb begin
        w_range_bad = 1'b0;
        case (i_opcode)
            OP_LUI, OP_AUIPC: w_range_bad = |i_imm[11:0];
            OP_JAL:           w_range_bad = !f_sext_ok(i_imm, 20) || i_imm[0];
            OP_BRANCH:        w_range_bad = !f_sext_ok(i_imm, 12) || i_imm[0];
            OP_STORE, OP_LOAD, OP_JALR: w_range_bad = !f_sext_ok(i_imm, 11);
            OP_IMM: begin
                if (w_is_shift) w_range_bad = |i_imm[31:5];
                else            w_range_bad = !f_sext_ok(i_imm, 11);
            end
            OP_SYSTEM:        w_range_bad = |i_imm[31:5];
            default:          w_range_bad = 1'b0;
        endcase
    end
`else
    assign w_range_bad = 1'b0;
`endif

    assign w_bad   = w_illegal | w_range_bad;
    assign w_entry = '{err: w_bad, instr: (w_bad ? NOP : w_enc)};

    // Ready comes only from the registered count; a full FIFO does not accept even if popping.
    assign o_ready = (r_count < DEPTH_C);
    assign o_valid = (r_count != '0);
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    assign o_instr   = o_valid ? r_mem[r_rd_ptr].instr : 32'h0;
    assign o_err     = o_valid ? r_mem[r_rd_ptr].err : 1'b0;
    assign o_err_cnt = r_err_cnt;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_bad && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words queued at request acceptance,
// compared when the DUT hands a word downstream.
module tb_instr_encoder;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [6:0]  i_opcode;
    logic [4:0]  i_rd, i_rs1, i_rs2;
    logic [2:0]  i_funct3;
    logic [6:0]  i_funct7;
    logic [11:0] i_csr;
    logic [31:0] i_imm;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic        o_err;
    logic [7:0]  o_err_cnt;

    int          n_checks = 0;
    int          n_errs   = 0;
    int          n_popped = 0;
    int          exp_cnt  = 0;
    logic [32:0] sb [$];

    instr_encoder #(.FIFO_DEPTH(2), .ERR_CNT_W(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
        .i_funct3(i_funct3), .i_funct7(i_funct7), .i_csr(i_csr), .i_imm(i_imm),
        .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_err(o_err),
        .o_err_cnt(o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] rd,
            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
            input logic [6:0] f7, input logic [11:0] csr, input logic [31:0] imm);
        logic [31:0] w;
        logic bad, rng;
        w = 32'h0; bad = 1'b0; rng = 1'b0;
        case (op)
            7'h37, 7'h17: begin
                w = {imm[31:12], rd, op};
                rng = (imm[11:0] != 12'h0);
            end
            7'h6F: begin
                w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                rng = !(imm[31:20] == 12'h0 || imm[31:20] == 12'hFFF) || imm[0];
            end
            7'h63: begin
                w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                rng = !(imm[31:12] == 20'h0 || imm[31:12] == 20'hFFFFF) || imm[0];
            end
            7'h23: begin
                w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                rng = !(imm[31:11] == 21'h0 || imm[31:11] == 21'h1FFFFF);
            end
            7'h03, 7'h67: begin
                w = {imm[11:0], rs1, f3, rd, op};
                rng = !(imm[31:11] == 21'h0 || imm[31:11] == 21'h1FFFFF);
            end
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    w = {f7, imm[4:0], rs1, f3, rd, op};
                    rng = (imm[31:5] != 27'h0);
                end else begin
                    w = {imm[11:0], rs1, f3, rd, op};
                    rng = !(imm[31:11] == 21'h0 || imm[31:11] == 21'h1FFFFF);
                end
            end
            7'h33: w = {f7, rs2, rs1, f3, rd, op};
            7'h73: begin
                w = {csr, imm[4:0], f3, rd, op};
                rng = (imm[31:5] != 27'h0);
            end
            default: bad = 1'b1;
        endcase
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        bad = bad | rng;
`endif
        return bad ? {1'b1, 32'h00000013} : {1'b0, w};
    endfunction

    // Inputs change 1 time unit after posedge; handshakes are observed on the negedge.
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
            input logic [11:0] csr, input logic [31:0] imm, input bit rnd_rdy);
        logic [32:0] e;
        bit ok;
        i_opcode = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_funct3 = f3;
        i_funct7 = f7; i_csr = csr; i_imm = imm; i_valid = 1'b1;
        if (rnd_rdy) i_ready = 1'($urandom_range(0, 1));
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge i_clk);
            if (o_ready) begin ok = 1'b1; break; end
            @(posedge i_clk); #1;
            i_ready = 1'b1;
        end
        if (!ok) chk("send_timeout", 64'(o_ready), 64'd1);
        else begin
            e = model(op, rd, rs1, rs2, f3, f7, csr, imm);
            sb.push_back(e);
            if (e[32] && exp_cnt != 255) exp_cnt++;
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        i_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge i_clk);
            if (sb.size() == 0 && !o_valid) break;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
        chk("drain_valid", 64'(o_valid), 64'd0);
        @(posedge i_clk); #1;
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready) begin
            if (sb.size() == 0) chk("sb_underflow", {31'h0, o_err, o_instr}, 64'h0);
            else chk("word", {31'h0, o_err, o_instr}, {31'h0, sb.pop_front()});
            n_popped++;
        end
    end

    initial begin
        logic [6:0] ops [11];
        logic [31:0] first_word;
        int p0;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h63, 7'h23, 7'h03, 7'h67, 7'h13, 7'h33, 7'h73, 7'h7F};
        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_opcode = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0; i_funct3 = '0;
        i_funct7 = '0; i_csr = '0; i_imm = '0;
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_instr", 64'(o_instr), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_cnt", 64'(o_err_cnt), 64'd0);
        @(posedge i_clk); #1;

        // ADDI with downstream stalled: one-cycle latency and stable output
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'hFFFFFFFF, 1'b0);
        chk("addi_valid", 64'(o_valid), 64'd1);
        chk("addi_instr", 64'(o_instr), 64'hFFF00093);
        chk("addi_err", 64'(o_err), 64'd0);
        first_word = o_instr;
        @(posedge i_clk); #1;
        chk("stall_stable", 64'(o_instr), 64'(first_word));
        drain();

        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd8, 1'b0);
        chk("jal_instr", 64'(o_instr), 64'h008000EF);
        drain();
        send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'h12345000, 1'b0);
        chk("lui_instr", 64'(o_instr), 64'h123452B7);
        drain();

        send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd3, 1'b0);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        chk("beq_err", 64'(o_err), 64'd1);
        chk("beq_instr", 64'(o_instr), 64'h00000013);
`else
        chk("beq_err", 64'(o_err), 64'd0);
        chk("beq_instr", 64'(o_instr), 64'h00000163);
`endif
        drain();
        chk("beq_cnt", 64'(o_err_cnt), 64'(exp_cnt));

        send(7'h7F, 5'd3, 5'd4, 5'd5, 3'd2, 7'd1, 12'd9, 32'h0, 1'b0);
        chk("bad_op_err", 64'(o_err), 64'd1);
        chk("bad_op_instr", 64'(o_instr), 64'h00000013);
        drain();
        chk("bad_op_cnt", 64'(o_err_cnt), 64'(exp_cnt));

        // Backpressure: FIFO fills at two words, then releases all three in order
        p0 = n_popped;
        i_ready = 1'b0;
        send(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 12'd0, 32'h0, 1'b0);
        send(7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 12'd0, 32'hFFFFFFF8, 1'b0);
        chk("full_ready", 64'(o_ready), 64'd0);
        chk("full_valid", 64'(o_valid), 64'd1);
        i_ready = 1'b1;
        send(7'h73, 5'd7, 5'd0, 5'd0, 3'd1, 7'd0, 12'h300, 32'd5, 1'b0);
        drain();
        chk("bp_count", 64'(n_popped - p0), 64'd3);

        for (int k = 0; k < 60; k++) begin
            logic [31:0] imm;
            imm = ($urandom_range(0, 1) == 1) ? {{20{$urandom_range(0, 1) == 1}}, 12'($urandom)} : $urandom;
            send(ops[$urandom_range(0, 10)], 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 7'($urandom), 12'($urandom), imm, 1'b1);
        end
        drain();
        chk("rand_cnt", 64'(o_err_cnt), 64'(exp_cnt));

        i_ready = 1'b1;
        repeat (260) send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'd0, 1'b0);
        drain();
        chk("sat_cnt", 64'(o_err_cnt), 64'd255);

        // Reset with two words buffered
        i_ready = 1'b0;
        send(7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 12'd0, 32'd1, 1'b0);
        send(7'h13, 5'd4, 5'd3, 5'd0, 3'd0, 7'd0, 12'd0, 32'd2, 1'b0);
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        sb.delete();
        exp_cnt = 0;
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_ready", 64'(o_ready), 64'd1);
        chk("mid_rst_cnt", 64'(o_err_cnt), 64'd0);
        chk("mid_rst_instr", 64'(o_instr), 64'd0);
        i_ready = 1'b1;
        p0 = n_popped;
        repeat (3) @(posedge i_clk);
        #1;
        chk("no_stale", 64'(n_popped - p0), 64'd0);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 12'd0, 32'hFFFFFFFF, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: output buffer entries, power of two, >=2.
REQ-002 Parameter ERR_CNT_W, default 8: width of saturating error counter.
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  in  1  synchronous active-low reset.
REQ-005 i_valid  in  1  upstream request valid.
REQ-006 o_ready  out  1  block accepts request this cycle.
REQ-007 i_opcode  in  7  RV32I opcode, bits [6:0] of the result.
REQ-008 i_rd / i_rs1 / i_rs2  in  5 each  register fields.
REQ-009 i_funct3  in  3; i_funct7  in  7  function fields.
REQ-010 i_csr  in  12  CSR address, CSR opcode only.
REQ-011 i_imm  in  32  full sign-extended immediate value; zimm for CSR.
REQ-012 o_valid  out  1  encoded word available.
REQ-013 i_ready  in  1  downstream accepts word.
REQ-014 o_instr  out  32  encoded instruction.
REQ-015 o_err  out  1  word replaced because request was illegal.
REQ-016 o_err_cnt  out  ERR_CNT_W  count of illegal requests.

Function
REQ-017 Request accepted when i_valid & o_ready; response accepted when o_valid & i_ready.
REQ-018 o_ready = (FIFO occupancy < FIFO_DEPTH), from registered count; no same-cycle full bypass.
REQ-019 Latency: request accepted in cycle N, word visible on o_instr/o_valid in N+1 if FIFO was empty.
REQ-020 Order preserved; o_instr/o_err stable while o_valid & !i_ready.
REQ-021 Packing, inverse of decode: U (0110111, 0010111): {imm[31:12], rd, op}; J (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
REQ-022 B (1100011): {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}; S (0100011): {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
REQ-023 I (0000011, 1100111, 0010011 f3 not 001/101): {imm[11:0], rs1, f3, rd, op}; shift (0010011 f3 001/101): {f7, imm[4:0], rs1, f3, rd, op}.
REQ-024 R (0110011): {f7, rs2, rs1, f3, rd, op}, i_imm ignored; CSR (1110011): {i_csr, imm[4:0], f3, rd, op}.
REQ-025 Any other opcode: illegal; o_instr = 32'h00000013, o_err=1.
REQ-026 Simultaneous push and pop with nonfull FIFO: both occur, occupancy unchanged.
REQ-027 Pointers wrap modulo FIFO_DEPTH; o_err_cnt saturates at all-ones, never wraps.

Reset
REQ-028 While !i_rst_n at a rising edge: FIFO flushed, occupancy 0, o_valid=0, o_ready=1 on next cycle, o_instr=0, o_err=0, o_err_cnt=0.
REQ-029 Reset mid-operation discards all buffered words; no partial word emitted after reset release.

Configuration
REQ-030 Macro INSTR_ENCODER_RANGE_CHECK_EN defined: request illegal also when immediate does not fit: I/S imm[31:11] not uniform; B imm[31:12] not uniform or imm[0]=1; J imm[31:20] not uniform or imm[0]=1; U imm[11:0]!=0; shift/CSR imm[31:5]!=0.
REQ-031 Range-illegal request emits 32'h00000013 with o_err=1 and increments o_err_cnt.
REQ-032 Macro undefined: no range check, out-of-range bits silently truncated, only REQ-025 sets o_err.

Verification
REQ-033 ADDI op=0010011, rd=1, rs1=0, f3=0, imm=32'hFFFFFFFF -> next cycle o_valid=1, o_instr=32'hFFF00093, o_err=0.
REQ-034 JAL op=1101111, rd=1, imm=8 -> o_instr=32'h008000EF; LUI rd=5, imm=32'h12345000 -> o_instr=32'h123452B7.
REQ-035 With macro: BEQ op=1100011, imm=3 -> o_instr=32'h00000013, o_err=1, o_err_cnt=1; without macro: o_err=0.
REQ-036 Opcode 7'b1111111 -> o_instr=32'h00000013, o_err=1 in both configurations.
REQ-037 i_ready=0, push 3 back-to-back -> o_ready low after 2; i_ready=1 -> 3 words out in order, no loss or duplicate.
REQ-038 Two words buffered, i_rst_n=0 one cycle -> o_valid=0, o_err_cnt=0, o_ready=1, no stale word afterwards.
